// File: rtl/lcd_window_ctrl.sv
// rtl/lcd_window_ctrl.sv - LCD CASET/RASET/RAMWR window setup and RGB565 pixel byte streamer
// Build option: LCD_PIXEL_SWAP_EN sends the low pixel byte before the high byte.
module lcd_window_ctrl #(
    parameter int unsigned COL_OFS = 40,
    parameter int unsigned ROW_OFS = 53,
    parameter int unsigned WIDTH   = 240,
    parameter int unsigned HEIGHT  = 135
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  x0,
    input  logic [7:0]  x1,
    input  logic [7:0]  y0,
    input  logic [7:0]  y1,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_dc
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CASET_CMD,
        ST_CASET_DAT,
        ST_RASET_CMD,
        ST_RASET_DAT,
        ST_RAMWR_CMD,
        ST_PIX_WAIT,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_DONE
    } state_t;

    localparam logic [15:0] COL_OFS16 = 16'(COL_OFS);
    localparam logic [15:0] ROW_OFS16 = 16'(ROW_OFS);
    localparam logic [15:0] WIDTH16   = 16'(WIDTH);
    localparam logic [15:0] HEIGHT16  = 16'(HEIGHT);

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    state_t      state_q, state_d;
    logic [7:0]  x0_q, x0_d;
    logic [7:0]  x1_q, x1_d;
    logic [7:0]  y0_q, y0_d;
    logic [7:0]  y1_q, y1_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] pix_q, pix_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] total_q, total_d;
    logic        err_q, err_d;

    logic        win_bad;
    logic [15:0] win_w, win_h;
    logic [15:0] col_s, col_e, row_s, row_e;
    logic [7:0]  pix_first, pix_second;

    function automatic logic [7:0] coord_byte(input logic [1:0] idx,
                                              input logic [15:0] s,
                                              input logic [15:0] e);
        logic [15:0] word;
        word = idx[1] ? e : s;
        return idx[0] ? word[7:0] : word[15:8];
    endfunction

    assign win_bad = (x0 > x1) || (y0 > y1) ||
                     ({8'd0, x1} >= WIDTH16) || ({8'd0, y1} >= HEIGHT16);

    // Window dimensions are only meaningful when win_bad is low.
    assign win_w = {8'd0, x1} - {8'd0, x0} + 16'd1;
    assign win_h = {8'd0, y1} - {8'd0, y0} + 16'd1;

    assign col_s = {8'd0, x0_q} + COL_OFS16;
    assign col_e = {8'd0, x1_q} + COL_OFS16;
    assign row_s = {8'd0, y0_q} + ROW_OFS16;
    assign row_e = {8'd0, y1_q} + ROW_OFS16;

`ifdef LCD_PIXEL_SWAP_EN
    assign pix_first  = pix_q[7:0];
    assign pix_second = pix_q[15:8];
`else
    assign pix_first  = pix_q[15:8];
    assign pix_second = pix_q[7:0];
`endif

    assign err = err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            x0_q      <= 8'd0;
            x1_q      <= 8'd0;
            y0_q      <= 8'd0;
            y1_q      <= 8'd0;
            idx_q     <= 2'd0;
            pix_q     <= 16'd0;
            pix_cnt_q <= 16'd0;
            total_q   <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            idx_q     <= idx_d;
            pix_q     <= pix_d;
            pix_cnt_q <= pix_cnt_d;
            total_q   <= total_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        idx_d      = idx_q;
        pix_d      = pix_q;
        pix_cnt_d  = pix_cnt_q;
        total_d    = total_q;
        err_d      = 1'b0;
        busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done       = (state_q == ST_DONE);
        pix_ready  = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'hFF;
        byte_dc    = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (win_bad) begin
                        err_d = 1'b1;
                    end else begin
                        x0_d      = x0;
                        x1_d      = x1;
                        y0_d      = y0;
                        y1_d      = y1;
                        idx_d     = 2'd0;
                        pix_cnt_d = 16'd0;
                        total_d   = win_w * win_h;
                        state_d   = ST_CASET_CMD;
                    end
                end
            end
            ST_CASET_CMD: begin
                byte_valid = 1'b1;
                byte_data  = CMD_CASET;
                byte_dc    = 1'b0;
                if (byte_ready) begin
                    idx_d   = 2'd0;
                    state_d = ST_CASET_DAT;
                end
            end
            ST_CASET_DAT: begin
                byte_valid = 1'b1;
                byte_data  = coord_byte(idx_q, col_s, col_e);
                if (byte_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_RASET_CMD;
                    end
                end
            end
            ST_RASET_CMD: begin
                byte_valid = 1'b1;
                byte_data  = CMD_RASET;
                byte_dc    = 1'b0;
                if (byte_ready) begin
                    idx_d   = 2'd0;
                    state_d = ST_RASET_DAT;
                end
            end
            ST_RASET_DAT: begin
                byte_valid = 1'b1;
                byte_data  = coord_byte(idx_q, row_s, row_e);
                if (byte_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_RAMWR_CMD;
                    end
                end
            end
            ST_RAMWR_CMD: begin
                byte_valid = 1'b1;
                byte_data  = CMD_RAMWR;
                byte_dc    = 1'b0;
                if (byte_ready) begin
                    state_d = ST_PIX_WAIT;
                end
            end
            ST_PIX_WAIT: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    pix_d     = pix_data;
                    pix_cnt_d = pix_cnt_q + 16'd1;
                    state_d   = ST_PIX_HI;
                end
            end
            ST_PIX_HI: begin
                byte_valid = 1'b1;
                byte_data  = pix_first;
                if (byte_ready) begin
                    state_d = ST_PIX_LO;
                end
            end
            ST_PIX_LO: begin
                byte_valid = 1'b1;
                byte_data  = pix_second;
                // pix_cnt_q already includes the pixel being sent.
                if (byte_ready) begin
                    state_d = (pix_cnt_q == total_q) ? ST_DONE : ST_PIX_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_window_ctrl.sv
// tb/tb_lcd_window_ctrl.sv - directed table-driven bench for lcd_window_ctrl
module tb_lcd_window_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  x0, x1, y0, y1;
    logic        busy, done, err;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        byte_dc;

    always #5 clk = ~clk;

    lcd_window_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc)
    );

    typedef struct {
        logic [7:0]  x0, x1, y0, y1;
        logic [15:0] pix;
        int          exp_err;
        logic [63:0] exp_coord;
        int          exp_pix;
    } vec_t;

    vec_t vecs[9];

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] byte_log[$];
    int pix_cnt   = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int busy_cnt  = 0;
    int done_busy = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (byte_valid && byte_ready) byte_log.push_back({byte_dc, byte_data});
            if (pix_valid && pix_ready) pix_cnt++;
            if (done) done_cnt++;
            if (done && busy) done_busy++;
            if (err) err_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] b0, input logic [7:0] b1);
        x0 = a0; x1 = a1; y0 = b0; y1 = b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_end_in_budget", (n < budget) ? 1 : 0, 1);
    endtask

    function automatic logic [8:0] exp_hdr(input int i, input logic [63:0] c);
        if (i == 0) return {1'b0, 8'h2A};
        if (i >= 1 && i <= 4) return {1'b1, c[63 - 8*(i-1) -: 8]};
        if (i == 5) return {1'b0, 8'h2B};
        if (i >= 6 && i <= 9) return {1'b1, c[31 - 8*(i-6) -: 8]};
        return {1'b0, 8'h2C};
    endfunction

    function automatic logic [7:0] first_byte(input logic [15:0] p);
`ifdef LCD_PIXEL_SWAP_EN
        return p[7:0];
`else
        return p[15:8];
`endif
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] p);
`ifdef LCD_PIXEL_SWAP_EN
        return p[15:8];
`else
        return p[7:0];
`endif
    endfunction

    initial begin
        int b0, d0, e0, p0, bz0, db0, bad;

        vecs[0] = '{8'd5,   8'd5,   8'd7,   8'd7,   16'hF800, 0, 64'h002D_002D_003C_003C, 1};
        vecs[1] = '{8'd10,  8'd9,   8'd0,   8'd0,   16'h0000, 1, 64'h0, 0};
        vecs[2] = '{8'd0,   8'd0,   8'd3,   8'd2,   16'h0000, 1, 64'h0, 0};
        vecs[3] = '{8'd0,   8'd240, 8'd0,   8'd0,   16'h0000, 1, 64'h0, 0};
        vecs[4] = '{8'd0,   8'd0,   8'd0,   8'd135, 16'h0000, 1, 64'h0, 0};
        vecs[5] = '{8'd0,   8'd3,   8'd0,   8'd1,   16'h1234, 0, 64'h0028_002B_0035_0036, 8};
        vecs[6] = '{8'd230, 8'd239, 8'd130, 8'd134, 16'h07E0, 0, 64'h010E_0117_00B7_00BB, 50};
        vecs[7] = '{8'd239, 8'd239, 8'd134, 8'd134, 16'hABCD, 0, 64'h0117_0117_00BB_00BB, 1};
        vecs[8] = '{8'd0,   8'd0,   8'd0,   8'd134, 16'h00FF, 0, 64'h0028_0028_0035_00BB, 135};

        resetn = 1'b0; start = 1'b0;
        x0 = 8'd0; x1 = 8'd0; y0 = 8'd0; y1 = 8'd0;
        pix_valid = 1'b1; pix_data = 16'h0000; byte_ready = 1'b1;
        #12;
        check("rst_busy",       busy,       1'b0);
        check("rst_done",       done,       1'b0);
        check("rst_err",        err,        1'b0);
        check("rst_pix_ready",  pix_ready,  1'b0);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_byte_data",  byte_data,  8'hFF);
        check("rst_byte_dc",    byte_dc,    1'b1);
        tick();
        resetn = 1'b1;
        repeat (3) tick();

        // First byte appears the cycle after the accepting edge.
        b0 = byte_log.size(); d0 = done_cnt; e0 = err_cnt;
        pix_data = 16'hF800;
        do_start(8'd5, 8'd5, 8'd7, 8'd7);
        @(negedge clk);
        check("first_busy",       busy,       1'b1);
        check("first_byte_valid", byte_valid, 1'b1);
        check("first_byte_data",  byte_data,  8'h2A);
        check("first_byte_dc",    byte_dc,    1'b0);
        wait_end(d0, e0, 200);

        // New start in the cycle right after done.
        @(posedge clk); #1;
        d0 = done_cnt;
        do_start(8'd5, 8'd5, 8'd7, 8'd7);
        @(negedge clk);
        check("b2b_busy",      busy,      1'b1);
        check("b2b_byte_data", byte_data, 8'h2A);
        wait_end(d0, e0, 200);
        repeat (3) tick();

        for (int v = 0; v < 9; v++) begin
            b0 = byte_log.size(); d0 = done_cnt; e0 = err_cnt; p0 = pix_cnt;
            bz0 = busy_cnt; db0 = done_busy;
            pix_data = vecs[v].pix;
            do_start(vecs[v].x0, vecs[v].x1, vecs[v].y0, vecs[v].y1);
            wait_end(d0, e0, 2000);
            repeat (3) tick();
            check($sformatf("v%0d_err_pulses", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("v%0d_pixels", v), pix_cnt - p0, vecs[v].exp_pix);
            if (vecs[v].exp_err != 0) begin
                check($sformatf("v%0d_no_bytes", v), byte_log.size() - b0, 0);
                check($sformatf("v%0d_no_busy", v), busy_cnt - bz0, 0);
                check($sformatf("v%0d_no_done", v), done_cnt - d0, 0);
            end else begin
                check($sformatf("v%0d_done_pulses", v), done_cnt - d0, 1);
                check($sformatf("v%0d_done_busy", v), done_busy - db0, 0);
                check($sformatf("v%0d_byte_count", v), byte_log.size() - b0,
                      11 + 2 * vecs[v].exp_pix);
                bad = 0;
                for (int i = 0; i < 11; i++) begin
                    if (b0 + i >= byte_log.size() ||
                        byte_log[b0 + i] !== exp_hdr(i, vecs[v].exp_coord)) bad++;
                end
                check($sformatf("v%0d_hdr_bytes_bad", v), bad, 0);
                bad = 0;
                for (int k = 0; k < vecs[v].exp_pix; k++) begin
                    if (b0 + 12 + 2*k >= byte_log.size()) bad++;
                    else begin
                        if (byte_log[b0 + 11 + 2*k] !== {1'b1, first_byte(vecs[v].pix)})  bad++;
                        if (byte_log[b0 + 12 + 2*k] !== {1'b1, second_byte(vecs[v].pix)}) bad++;
                    end
                end
                check($sformatf("v%0d_pix_bytes_bad", v), bad, 0);
            end
        end

        // Back-pressure on the 3rd byte of a full window, with an ignored start.
        b0 = byte_log.size(); e0 = err_cnt;
        pix_data = 16'h5555;
        do_start(8'd0, 8'd239, 8'd0, 8'd134);
        tick();
        tick();
        byte_ready = 1'b0;
        x0 = 8'd10; x1 = 8'd9;
        start = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (byte_valid !== 1'b1 || byte_data !== 8'h28 || byte_dc !== 1'b1) bad++;
            tick();
            start = 1'b0;
        end
        check("stall_hold_bad_cycles", bad, 0);
        byte_ready = 1'b1;
        for (int n = 0; n < 100 && byte_log.size() < b0 + 11; n++) tick();
        check("stall_err_ignored", err_cnt - e0, 0);
        bad = 0;
        for (int i = 0; i < 11; i++) begin
            if (b0 + i >= byte_log.size() ||
                byte_log[b0 + i] !== exp_hdr(i, 64'h0028_0117_0035_00BB)) bad++;
        end
        check("full_hdr_bytes_bad", bad, 0);
        check("full_still_busy", busy, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Reset while pixel 100 of a 2x100 window is in flight.
        p0 = pix_cnt;
        pix_data = 16'h0F0F;
        do_start(8'd0, 8'd1, 8'd0, 8'd99);
        for (int n = 0; n < 1000 && pix_cnt - p0 < 100; n++) begin
            @(negedge clk);
            #1;
        end
        check("mid_pixels_reached", pix_cnt - p0, 100);
        check("mid_busy_before", busy, 1'b1);
        resetn = 1'b0;
        #1;
        check("mid_rst_busy",       busy,       1'b0);
        check("mid_rst_byte_valid", byte_valid, 1'b0);
        check("mid_rst_pix_ready",  pix_ready,  1'b0);
        check("mid_rst_byte_data",  byte_data,  8'hFF);
        tick();
        tick();
        b0 = byte_log.size();
        resetn = 1'b1;
        repeat (5) tick();
        check("post_rst_no_bytes", byte_log.size() - b0, 0);
        check("post_rst_idle",     busy, 1'b0);
        d0 = done_cnt; e0 = err_cnt;
        do_start(8'd5, 8'd5, 8'd7, 8'd7);
        @(negedge clk);
        check("post_rst_byte_valid", byte_valid, 1'b1);
        check("post_rst_byte_data",  byte_data,  8'h2A);
        check("post_rst_byte_dc",    byte_dc,    1'b0);
        wait_end(d0, e0, 200);
        check("post_rst_done", done_cnt - d0, 1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_window_ctrl.md
LCD_WINDOW_CTRL -- requirements
Module: lcd_window_ctrl

Interface
REQ-001 SHALL have parameter COL_OFS, default 40, column offset added to every x coordinate.
REQ-002 SHALL have parameter ROW_OFS, default 53, row offset added to every y coordinate.
REQ-003 SHALL have parameter WIDTH, default 240, visible columns.
REQ-004 SHALL have parameter HEIGHT, default 135, visible rows.
REQ-005 SHALL have ports:
- clk  in  1  system clock (27 MHz); one clock domain.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  window-write request.
- x0, x1  in  8 each  inclusive column bounds.
- y0, y1  in  8 each  inclusive row bounds.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle invalid-window pulse.
- pix_valid  in  1  pixel available.
- pix_ready  out  1  pixel accepted.
- pix_data  in  16  RGB565 pixel.
- byte_valid  out  1  byte to the SPI byte engine.
- byte_ready  in  1  SPI engine accepts byte.
- byte_data  out  8  byte value.
- byte_dc  out  1  0 = command, 1 = data (LCD RS).

Function
REQ-006 SHALL accept start only in IDLE; start while busy is ignored.
REQ-007 SHALL treat a window as invalid if x0>x1, y0>y1, x1>=WIDTH or y1>=HEIGHT; on start it pulses err for 1 cycle, stays IDLE and keeps busy low.
REQ-008 SHALL latch x0..y1 on a valid start and assert busy from the next cycle until done.
REQ-009 SHALL use states IDLE -> CASET_CMD -> CASET_DAT(4) -> RASET_CMD -> RASET_DAT(4) -> RAMWR_CMD -> PIX_WAIT -> PIX_HI -> PIX_LO -> (PIX_WAIT or DONE) -> IDLE.
REQ-010 SHALL emit the following byte sequence:
- 0x2A with dc=0.
- x0+COL_OFS and x1+COL_OFS as 16-bit big-endian, dc=1.
- 0x2B with dc=0.
- y0+ROW_OFS and y1+ROW_OFS as 16-bit big-endian, dc=1.
- 0x2C with dc=0.
- Pixel bytes with dc=1.
REQ-011 SHALL compute offset sums at 16-bit width with no truncation.
REQ-012 SHALL present byte_valid=1 with the first byte (0x2A) in the cycle after the start is accepted.
REQ-013 SHALL count a byte transfer only when byte_valid and byte_ready are both high on a clock edge.
REQ-014 SHALL hold byte_data and byte_dc stable while byte_valid=1 and byte_ready=0.
REQ-015 SHALL drive byte_valid=0 when no byte is pending.
REQ-016 SHALL assert pix_ready only in PIX_WAIT, when no byte is pending.
REQ-017 SHALL latch pix_data on pix_valid & pix_ready, then send the high byte followed by the low byte.
REQ-018 SHALL transfer exactly (x1-x0+1)*(y1-y0+1) pixels, counted in a 16-bit counter (maximum 32400; no wrap).
REQ-019 SHALL handle the pixel count boundaries as follows:
- A 1x1 window transfers exactly one pixel.
- A full window transfers 32400 pixels.
REQ-020 SHALL pulse done for 1 cycle after the last pixel's second byte transfers, and drive busy low in that same cycle.
REQ-021 SHALL ignore pix_valid outside PIX_WAIT.
REQ-022 SHALL accept a new start in the cycle after done.

Reset
REQ-023 SHALL, on resetn low, immediately (asynchronously) enter IDLE, including mid-transaction.
REQ-024 SHALL drive these values during reset:
- busy=0, done=0, err=0, pix_ready=0, byte_valid=0.
- byte_data=0xFF, byte_dc=1.
- Pixel counter and latched coordinates cleared.
REQ-025 SHALL resume operation on the first clk edge after resetn rises and issue no bytes until a new start.

Configuration
REQ-026 SHALL support macro LCD_PIXEL_SWAP_EN:
- Defined: each pixel sends pix_data[7:0] first, then pix_data[15:8].
- Undefined: each pixel sends pix_data[15:8] first, then pix_data[7:0].
- Command and coordinate bytes are unaffected in both cases.

Verification
REQ-027 SHALL pass: start with x0=0,x1=239,y0=0,y1=134 and byte_ready=1 -> bytes 2A,00,28,01,17,2B,00,35,00,BB,2C with dc 0,1,1,1,1,0,1,1,1,1,0; then 64800 pixel bytes; one done pulse.
REQ-028 SHALL pass: 1x1 window at x=5,y=7 with pix_data=0xF800 -> CASET data 00,2D,00,2D; RASET data 00,3C,00,3C; pixel bytes F8,00; done.
REQ-029 SHALL pass: start with x0=10,x1=9 -> err pulse 1 cycle, busy stays 0, no byte_valid.
REQ-030 SHALL pass: byte_ready held low 5 cycles on the 3rd byte -> byte_data=0x28 and dc=1 held stable; sequence otherwise unchanged.
REQ-031 SHALL pass: resetn low during pixel 100 of a 2x100 window -> busy=0, byte_valid=0, pix_ready=0 immediately; a new start reissues 0x2A.
REQ-032 SHALL pass: with LCD_PIXEL_SWAP_EN defined, pix_data=0x07E0 -> bytes E0 then 07.
